// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants and helpers for the writeback arbiter
//
// Purpose: widths, the zero-register index and the round-robin pointer helper
//          used by rf_wb_arbiter and rr_pick.
// Ports:   none (package).
package rf_wb_arbiter_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_AW    = 5;
  localparam int ZERO_REG = 0;

  // Upper bound on requesters; grant_id and the pointer are sized for it.
  localparam int MAX_REQ  = 8;
  localparam int GID_W    = 3;

  // Next pointer after granting index g among n requesters.
  function automatic logic [GID_W-1:0] rr_next(input logic [GID_W-1:0] g, input int n);
    logic [GID_W-1:0] nxt;
    if (int'(g) == n - 1) nxt = '0;
    else                  nxt = g + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// rtl/rf_wb_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: grants the first valid requester searching ptr, ptr+1, ... modulo NUM_REQ.
// Ports:
//   valid_i       in   NUM_REQ  request valid vector
//   ptr_i         in   3        search start index (0..NUM_REQ-1)
//   gnt_onehot_o  out  NUM_REQ  one-hot grant (zero when nothing valid)
//   gnt_idx_o     out  3        grant index (zero when nothing valid)
//   any_o         out  1        at least one requester valid
module rr_pick
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [GID_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_onehot_o,
  output logic [GID_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest valid requester
  // (smallest offset from ptr) is the one left standing.
  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    pos          = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (valid_i[i] && (pos == i)) begin
          gnt_onehot_o    = '0;
          gnt_onehot_o[i] = 1'b1;
          gnt_idx_o       = GID_W'(i);
        end
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin arbiter for the register file write port
//
// Purpose: accepts at most one writeback request per cycle into a registered
//          write stage driving the register file; writes to x0 are accepted
//          and dropped. Optional same-cycle read forwarding with RF_WB_FWD_EN.
// Ports:
//   clk        in   1             clock
//   rst_n      in   1             synchronous active-low reset
//   stall      in   1             blocks all accepts while high
//   req_valid  in   NUM_REQ       per-requester valid
//   req_ready  out  NUM_REQ       per-requester accept (combinational)
//   req_addr   in   NUM_REQ*AW    destination register, requester i at [i*AW +: AW]
//   req_data   in   NUM_REQ*XLEN  write data, requester i at [i*XLEN +: XLEN]
//   rf_we      out  1             register file write enable (registered)
//   rf_addr    out  AW            register file address (registered)
//   rf_wdata   out  XLEN          register file data (registered)
//   grant_id   out  3             requester owning rf_* this cycle (registered)
//   RF_WB_FWD_EN only:
//   fwd_addr1/2 in AW, fwd_rd1/2 in XLEN, fwd_out1/2 out XLEN
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = RF_XLEN,
  parameter int AW      = RF_AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_addr,
  output logic [XLEN-1:0]         rf_wdata,
`ifdef RF_WB_FWD_EN
  input  logic [AW-1:0]           fwd_addr1,
  input  logic [AW-1:0]           fwd_addr2,
  input  logic [XLEN-1:0]         fwd_rd1,
  input  logic [XLEN-1:0]         fwd_rd2,
  output logic [XLEN-1:0]         fwd_out1,
  output logic [XLEN-1:0]         fwd_out2,
`endif
  output logic [GID_W-1:0]        grant_id
);

  logic [GID_W-1:0]   ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [GID_W-1:0]   gid_q, gid_d;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [GID_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               accept;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .valid_i      (req_valid),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .any_o        (gnt_any)
  );

  // The picker only grants valid requesters, so a visible ready is a handshake.
  // Ready is masked in reset so nothing is accepted that the reset would lose.
  assign accept    = gnt_any & ~stall & rst_n;
  assign req_ready = gnt_onehot & {NUM_REQ{~stall & rst_n}};

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (accept) begin
      ptr_d  = rr_next(gnt_idx, NUM_REQ);
      // x0 is hard-wired zero: accept the request but never raise the enable.
      we_d   = (sel_addr != AW'(ZERO_REG));
      addr_d = sel_addr;
      data_d = sel_data;
      gid_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q  <= gid_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_addr  = addr_q;
  assign rf_wdata = data_q;
  assign grant_id = gid_q;

`ifdef RF_WB_FWD_EN
  // Register file reads return the old value during the write cycle; bypass it.
  assign fwd_out1 = (we_q && (addr_q == fwd_addr1) && (fwd_addr1 != AW'(ZERO_REG)))
                    ? data_q : fwd_rd1;
  assign fwd_out2 = (we_q && (addr_q == fwd_addr2) && (fwd_addr2 != AW'(ZERO_REG)))
                    ? data_q : fwd_rd2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  localparam int NR = 3;
  localparam int XL = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*XL-1:0] req_data;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [XL-1:0]   rf_wdata;
  logic [2:0]      grant_id;
`ifdef RF_WB_FWD_EN
  logic [AW-1:0]   fwd_addr1, fwd_addr2;
  logic [XL-1:0]   fwd_rd1, fwd_rd2, fwd_out1, fwd_out2;
`endif

  int total = 0;
  int bad   = 0;

  logic [XL-1:0] rf_model [32];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
`ifdef RF_WB_FWD_EN
    .fwd_addr1 (fwd_addr1),
    .fwd_addr2 (fwd_addr2),
    .fwd_rd1   (fwd_rd1),
    .fwd_rd2   (fwd_rd2),
    .fwd_out1  (fwd_out1),
    .fwd_out2  (fwd_out2),
`endif
    .grant_id  (grant_id)
  );

  // Stand-in register file fed by the write port.
  always @(posedge clk) begin
    if (rf_we) rf_model[rf_addr] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XL-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*XL +: XL] = d;
  endtask

  // Expected round-robin sequence with all three valid from ptr=0.
  int          exp_gid [4]  = '{0, 1, 2, 0};
  int          exp_addr [4] = '{1, 2, 3, 1};
  logic [31:0] exp_data [4] = '{32'hA, 32'hB, 32'hC, 32'hA};

  initial begin
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    rst_n     = 1'b0;
    stall     = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);
`ifdef RF_WB_FWD_EN
    fwd_addr1 = '0; fwd_addr2 = '0; fwd_rd1 = '0; fwd_rd2 = '0;
`endif

    // Reset held with everything valid.
    tick();
    tick();
    chk("rst_ready",  64'(req_ready), 64'd0);
    chk("rst_we",     64'(rf_we),     64'd0);
    chk("rst_addr",   64'(rf_addr),   64'd0);
    chk("rst_wdata",  64'(rf_wdata),  64'd0);
    chk("rst_gid",    64'(grant_id),  64'd0);

    // Release: req0 first, then round-robin 0,1,2,0.
    rst_n = 1'b1;
    #1;
    chk("first_ready", 64'(req_ready), 64'b001);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("rr_we%0d", n),    64'(rf_we),    64'd1);
      chk($sformatf("rr_gid%0d", n),   64'(grant_id), 64'(exp_gid[n]));
      chk($sformatf("rr_addr%0d", n),  64'(rf_addr),  64'(exp_addr[n]));
      chk($sformatf("rr_data%0d", n),  64'(rf_wdata), 64'(exp_data[n]));
    end
    // ptr is now 1.

    // Stall for three cycles.
    stall = 1'b1;
    #1;
    chk("stall1_ready", 64'(req_ready), 64'd0);
    chk("stall1_we",    64'(rf_we),     64'd1);
    tick();
    chk("stall2_ready", 64'(req_ready), 64'd0);
    chk("stall2_we",    64'(rf_we),     64'd0);
    tick();
    chk("stall3_ready", 64'(req_ready), 64'd0);
    chk("stall3_we",    64'(rf_we),     64'd0);
    stall = 1'b0;
    #1;
    chk("resume_ready", 64'(req_ready), 64'b010);
    tick();
    chk("resume_gid",   64'(grant_id), 64'd1);
    chk("resume_addr",  64'(rf_addr),  64'd2);
    tick();
    chk("resume2_gid",  64'(grant_id), 64'd2);
    // ptr is now 0.

    // x0 write from req1: accepted, dropped, pointer moves to 2.
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'hDEAD);
    #1;
    chk("x0_ready", 64'(req_ready), 64'b010);
    tick();
    chk("x0_we",  64'(rf_we),    64'd0);
    chk("x0_gid", 64'(grant_id), 64'd1);
    set_req(1, 5'd2, 32'hB);
    req_valid = 3'b111;
    #1;
    chk("x0_ptr", 64'(req_ready), 64'b100);
    req_valid = 3'b000;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("idle_we", 64'(rf_we), 64'd0);

    // Same address from two requesters: last granted wins.
    req_valid = 3'b001;
    set_req(0, 5'd5, 32'h11);
    #1;
    chk("same_ready0", 64'(req_ready), 64'b001);
    tick();
    chk("same_we0",   64'(rf_we),    64'd1);
    chk("same_data0", 64'(rf_wdata), 64'h11);
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'h22);
    tick();
    chk("same_we1",   64'(rf_we),    64'd1);
    chk("same_addr1", 64'(rf_addr),  64'd5);
    chk("same_data1", 64'(rf_wdata), 64'h22);
    chk("same_gid1",  64'(grant_id), 64'd1);
    req_valid = 3'b000;
    tick();
    chk("same_x5", 64'(rf_model[5]), 64'h22);
    chk("same_we_off", 64'(rf_we), 64'd0);

    // Reset mid-operation discards the pending accept.
    req_valid = 3'b111;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b001);

`ifdef RF_WB_FWD_EN
    // Load x7 = 0x55 via req0 and look at the bypass during the write cycle.
    req_valid = 3'b001;
    set_req(0, 5'd7, 32'h55);
    tick();
    req_valid = 3'b000;
    fwd_addr1 = 5'd7;  fwd_rd1 = 32'h0;
    fwd_addr2 = 5'd0;  fwd_rd2 = 32'h77;
    #1;
    chk("fwd1_hit",  64'(fwd_out1), 64'h55);
    chk("fwd2_x0",   64'(fwd_out2), 64'h77);
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h99);
    tick();
    req_valid = 3'b000;
    #1;
    chk("fwd2_rf0", 64'(fwd_out2), 64'h77);
    chk("fwd1_miss", 64'(fwd_out1), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
